// File: rtl/gray_serial_decoder_pkg.sv
// Shared types and Gray/binary helpers for the serial Gray decoder and its bench.
// The helpers work on a fixed 32-bit container; zero-extension leaves any narrower word's conversion unchanged.
package gray_serial_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_serial_decoder_if.sv
// Serial Gray bit input plus the decoded word output of the serial Gray decoder.
interface gray_serial_decoder_if #(
  parameter int WIDTH = 4
);
  logic             s_valid;
  logic             s_ready;
  logic             s_bit;
  logic             s_first;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             bin_valid;
  logic             bin_ready;
  logic             frame_err;

  modport master (
    output s_valid, s_bit, s_first, bin_ready,
    input  s_ready, bin, gray, bin_valid, frame_err
  );

  modport slave (
    input  s_valid, s_bit, s_first, bin_ready,
    output s_ready, bin, gray, bin_valid, frame_err
  );
endinterface

// File: rtl/gray_serial_decoder.sv
// Bit-serial Gray-to-binary decoder: MSB-first bits, running XOR decode, word on valid/ready.
// A new word may start in the same cycle the held word is handed off, so streaming has no bubbles.
module gray_serial_decoder
  import gray_serial_decoder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_serial_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_b;
  logic [WIDTH-1:0] r_acc_g;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_bin_valid;
  logic             r_frame_err;

  logic             w_s_ready;
  logic             w_beat;
  logic             w_hs;
  logic             w_start;
  logic             w_shift_beat;
  logic             w_err;
  logic             w_new_b;
  logic [WIDTH-1:0] w_acc_b_nxt;
  logic [WIDTH-1:0] w_acc_g_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;

  // Beat decode: a first-flagged beat always (re)starts a word; elsewhere only SHIFT extends one
  assign w_s_ready    = (r_state != HOLD) || bus.bin_ready;
  assign w_beat       = bus.s_valid && w_s_ready;
  assign w_hs         = r_bin_valid && bus.bin_ready;
  assign w_start      = w_beat && bus.s_first;
  assign w_shift_beat = w_start || (w_beat && (r_state == SHIFT));
  assign w_err        = w_beat && (bus.s_first ? (r_state == SHIFT) : (r_state != SHIFT));

  // Running XOR: the previous binary bit sits in the accumulator LSB
  assign w_new_b     = w_start ? bus.s_bit : (r_acc_b[0] ^ bus.s_bit);
  assign w_acc_b_nxt = w_start ? WIDTH'(bus.s_bit) : ((r_acc_b << 1) | WIDTH'(w_new_b));
  assign w_acc_g_nxt = w_start ? WIDTH'(bus.s_bit) : ((r_acc_g << 1) | WIDTH'(bus.s_bit));
  assign w_cnt_nxt   = w_start ? CNT_W'(1) : (r_cnt + 1'b1);
  assign w_done      = w_shift_beat && (w_cnt_nxt == CNT_W'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc_b     <= '0;
      r_acc_g     <= '0;
      r_bin       <= '0;
      r_gray      <= '0;
      r_bin_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_hs) begin
        r_bin_valid <= 1'b0;
      end
      if (w_shift_beat) begin
        r_acc_b <= w_acc_b_nxt;
        r_acc_g <= w_acc_g_nxt;
        r_cnt   <= w_cnt_nxt;
      end
      if (w_done) begin
        r_bin       <= w_acc_b_nxt;
        r_gray      <= w_acc_g_nxt;
        r_bin_valid <= 1'b1;
        r_cnt       <= '0;
        r_state     <= HOLD;
      end else if (w_shift_beat) begin
        r_state <= SHIFT;
      end else if (w_hs || (r_state == HOLD && !r_bin_valid)) begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.bin       = r_bin;
  assign bus.gray      = r_gray;
  assign bus.bin_valid = r_bin_valid;
  assign bus.frame_err = r_frame_err;

endmodule
